// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial subtractor computing d = a - b - bin, LSB first.
// Operands are latched on acceptance and processed one bit per clock, so
// operand changes after acceptance have no effect. Result, borrow-out and
// signed overflow are registered on entry to DONE and held until the
// consumer takes them.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             amsb_reg;
  logic             bmsb_reg;
  logic             bout_reg;
  logic             ovf_reg;

  // Current bit slice of the serial subtraction
  logic             ai;
  logic             bi;
  logic             di_next;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  assign ai       = a_sh_reg[0];
  assign bi       = b_sh_reg[0];
  assign di_next  = ai ^ bi ^ br_reg;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_reg);
  assign res_next = {di_next, res_reg[WIDTH-1:1]};

  // Handshake flags are pure decodes of the state register
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign d         = d_reg;
  assign bout      = bout_reg;
  assign ovf       = ovf_reg;

  // Control FSM plus serial datapath; outputs only change on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      amsb_reg  <= 1'b0;
      bmsb_reg  <= 1'b0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            br_reg    <= bin;
            amsb_reg  <= a[WIDTH-1];
            bmsb_reg  <= b[WIDTH-1];
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          res_reg  <= res_next;
          br_reg   <= br_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Last bit: di_next is the result MSB, br_next the final borrow
            d_reg     <= res_next;
            bout_reg  <= br_next;
            ovf_reg   <= (amsb_reg ^ bmsb_reg) & (di_next ^ amsb_reg);
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: directed and randomized checks of serial_sub8 against an
// arithmetic reference model (plain integer subtraction and range tests).
module tb_serial_sub8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_sub8 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer subtraction, unsigned borrow, signed range test
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mbin, output logic [W-1:0] ed,
                                output logic eb, output logic eo);
    int ua, ub, sa, sb, diff, sdiff;
    ua    = int'(ma);
    ub    = int'(mb);
    sa    = int'($signed(ma));
    sb    = int'($signed(mb));
    diff  = ua - ub - int'(mbin);
    ed    = W'(diff);
    eb    = (ua < ub + int'(mbin));
    sdiff = sa - sb - int'(mbin);
    eo    = (sdiff < -(1 << (W - 1))) || (sdiff > (1 << (W - 1)) - 1);
  endfunction

  // Present operands, accept, scramble inputs during RUN, check latency/result.
  // Called #1 after a rising edge with the DUT idle; leaves it in DONE.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input logic [W-1:0] sa, input logic [W-1:0] sb,
                        output logic [W-1:0] ed, output logic eb, output logic eo);
    int n;
    model(ta, tb_, tbin, ed, eb, eo);
    a = ta;
    b = tb_;
    bin = tbin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".accept"}, {31'd0, in_ready}, 32'd0);
    a = sa;
    b = sb;
    bin = 1'($urandom);
    in_valid = 1'($urandom);
    n = 0;
    while (n < 3 * W) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    check({tag, ".lat"}, n, W);
    check({tag, ".ovalid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".d"}, {24'd0, d}, {24'd0, ed});
    check({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    $display("op %s a=%h b=%h bin=%0d -> d=%h bout=%0d ovf=%0d lat=%0d (exp d=%h bout=%0d ovf=%0d)",
             tag, ta, tb_, tbin, d, bout, ovf, n, ed, eb, eo);
  endtask

  // Stay in DONE with out_ready low; outputs must not move
  task automatic hold_done(input string tag, input int cycles, input logic hv,
                           input logic [W-1:0] ed, input logic eb, input logic eo);
    out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      in_valid = hv;
      @(posedge clk);
      #1;
      check({tag, ".hold_d"}, {24'd0, d}, {24'd0, ed});
      check({tag, ".hold_bout"}, {31'd0, bout}, {31'd0, eb});
      check({tag, ".hold_ovf"}, {31'd0, ovf}, {31'd0, eo});
      check({tag, ".hold_ov"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".hold_ir"}, {31'd0, in_ready}, 32'd0);
    end
  endtask

  // Pulse out_ready for one edge; the DUT must be idle afterwards
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".rel_ov"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".rel_ir"}, {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
  } vec_t;

  vec_t dir[5];

  initial begin
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           hc;

    dir[0] = '{8'h5A, 8'h3C, 1'b0};
    dir[1] = '{8'h00, 8'h01, 1'b0};
    dir[2] = '{8'h00, 8'h00, 1'b1};
    dir[3] = '{8'h80, 8'h01, 1'b0};
    dir[4] = '{8'h7F, 8'hFF, 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ir", {31'd0, in_ready}, 32'd1);
    check("rst.ov", {31'd0, out_valid}, 32'd0);
    check("rst.d", {24'd0, d}, 32'd0);
    check("rst.bout", {31'd0, bout}, 32'd0);
    check("rst.ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic corners
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("dir%0d", i), dir[i].va, dir[i].vb, dir[i].vbin,
             W'($urandom), W'($urandom), ed, eb, eo);
      release_out($sformatf("dir%0d", i));
    end

    // Exact zero with borrow-in; operands overwritten during RUN
    run_op("zero", 8'h10, 8'h0F, 1'b1, 8'hFF, 8'h00, ed, eb, eo);
    check("zero.d_const", {24'd0, d}, 32'd0);
    release_out("zero");

    // Backpressure with the next operands already waiting on in_valid
    run_op("bp1", 8'h33, 8'h44, 1'b0, 8'h00, 8'h00, ed, eb, eo);
    a = 8'hC3;
    b = 8'h3C;
    bin = 1'b1;
    hold_done("bp1", 5, 1'b1, ed, eb, eo);
    release_out("bp1");
    run_op("bp2", 8'hC3, 8'h3C, 1'b1, W'($urandom), W'($urandom), ed, eb, eo);
    release_out("bp2");

    // Reset in the middle of RUN
    a = 8'h12;
    b = 8'h34;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.ov", {31'd0, out_valid}, 32'd0);
    check("midrst.ir", {31'd0, in_ready}, 32'd1);
    check("midrst.d", {24'd0, d}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.idle_ov", {31'd0, out_valid}, 32'd0);
    run_op("postrst", 8'hA5, 8'h5A, 1'b0, W'($urandom), W'($urandom), ed, eb, eo);
    check("postrst.d_const", {24'd0, d}, 32'h4B);
    check("postrst.ovf_const", {31'd0, ovf}, 32'd1);
    release_out("postrst");

    // Randomized operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, W'($urandom), W'($urandom), ed, eb, eo);
      hc = int'($urandom_range(0, 3));
      hold_done($sformatf("rnd%0d", i), hc, 1'($urandom), ed, eb, eo);
      in_valid = 1'b0;
      release_out($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
- Bit-serial, multi-cycle subtractor with a borrow-in input: computes D = A - B - bin, one bit per clock, LSB first.
- Provides a valid/ready handshake on both input and output.
- Intended as the area-lean inverse companion to the team's combinational 8-bit adders, and as a subtract stage in sequential datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/bin are valid
- in_ready  output  1  block is idle and can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result is valid and held
- out_ready  input  1  consumer accepts the result
- d  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin
- ovf  output  1  two's-complement overflow of a - b - bin

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1, out_valid=0, d=0, bout=0, ovf=0; bit counter=0; internal operand registers cleared.
- FSM states: IDLE, RUN, DONE.
  - in_ready is decoded from state: it is 1 only in IDLE.
  - out_valid is 1 only in DONE.
- IDLE:
  - On a rising edge with in_valid=1, latch a, b and bin into shift registers, copy the two operand MSBs for the ovf calculation, clear the counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN: one bit per cycle. Let ai/bi be the LSBs of the shift registers and br the running borrow (initialised to bin).
  - di = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - Shift both operand registers right; shift di into the MSB of the result register.
  - Increment the counter.
  - When the counter reaches WIDTH-1 on a cycle, the edge ending that cycle moves the FSM to DONE and registers d, bout = br_next, and ovf = (aMSB ^ bMSB) & (dMSB ^ aMSB).
- Latency: with acceptance at edge k, out_valid is first high after edge k+WIDTH, i.e. exactly WIDTH edges after acceptance. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE:
  - d, bout and ovf are held stable for as long as out_valid=1.
  - On an edge with out_ready=1, go to IDLE: out_valid=0 and in_ready=1 from the next cycle.
  - d, bout and ovf keep their last values in IDLE/RUN and are only updated on entry to DONE.
- Operand and borrow-in changes while in RUN or DONE are ignored, because the latched copies are used.
- in_valid asserted outside IDLE is ignored. No acceptance occurs in DONE even if out_ready=1 on the same edge; input and output handshakes never complete on the same edge.
- out_ready is a don't-care outside DONE.
- Reset mid-operation (RUN or DONE): the operation is aborted with no output produced, and every register returns to its reset value immediately.
- Arithmetic is exact modulo 2^WIDTH.
  - bout is the unsigned borrow.
  - ovf treats a and b as signed; bin is treated as an unsigned 0/1 subtracted from the signed difference.

Test Plan:
- Basic subtract: a=0x5A, b=0x3C, bin=0 -> d=0x1E, bout=0, ovf=0; out_valid rises exactly 8 edges after the accepting edge.
- Unsigned underflow: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0. Also a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1, ovf=0.
- Signed overflow: a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF, bin=0 -> d=0x80, bout=1, ovf=1.
- Borrow-in exact zero, with operands changed after acceptance: a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0, ovf=0. Drive a=0xFF, b=0x00 during RUN -> the result is unaffected.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - d/bout/ovf stay stable and in_ready stays 0.
  - After the out_ready pulse, in_ready=1 on the next cycle, and the held operands are accepted and computed correctly.
- Reset mid-RUN: assert rst_n=0 after 4 serial cycles -> out_valid=0, in_ready=1, d=0 immediately. After release, a=0xA5, b=0x5A, bin=0 -> d=0x4B, bout=0, ovf=1.
